memory_control_mmio: RTL and testbench

Parametrised successor to the LC-3 MAR/MDR memory controller. Adds configurable data/address width and memory depth, a multi-cycle memory access sequenced by an FSM with a proper ready (R) handshake, and abort on MIO_EN drop. Also decodes a memory-mapped I/O page: keyboard status/data and display status/data registers. Sits between the CPU bus and the control unit; o_Bus is gated onto the bus by the top level.

---
 rtl/memory_control_mmio.sv | 242 ++++++++++++++++++++++++
 tb/tb_memory_control_mmio.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_control_mmio.sv
// memory_control_mmio
//   MAR/MDR memory controller with a multi-cycle main-memory access sequenced
//   by a small FSM (IDLE -> BUSY -> READY), a ready bit (R) handshake, abort
//   when i_MIO_EN drops mid-access, and a memory-mapped I/O page holding the
//   keyboard (KBSR/KBDR) and display (DSR/DDR) registers.
//
// Ports
//   i_CLK         clock, rising edge
//   i_RST_N       asynchronous active-low reset
//   i_LD_MAR      load MAR from i_Bus[ADDR_W-1:0]
//   i_LD_MDR      load MDR (i_Bus when i_MIO_EN=0, read data in READY otherwise)
//   i_RW          1=write, 0=read (latched at access start)
//   i_MIO_EN      request a memory/IO access
//   i_Bus         CPU bus
//   i_KB_Valid    keyboard character strobe
//   i_KB_Data     keyboard character
//   i_Disp_Ready  display accepts the pending character
//   o_Bus         MDR contents
//   o_Ready_Bit   R: access completes this cycle
//   o_Disp_Valid  display character pending
//   o_Disp_Data   display character

module memory_control_mmio #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH       = 512,
  parameter int                MEM_LATENCY = 2,
  parameter logic [ADDR_W-1:0] MMIO_BASE   = 16'hFE00
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic              i_LD_MAR,
  input  logic              i_LD_MDR,
  input  logic              i_RW,
  input  logic              i_MIO_EN,
  input  logic [DATA_W-1:0] i_Bus,
  input  logic              i_KB_Valid,
  input  logic [7:0]        i_KB_Data,
  input  logic              i_Disp_Ready,
  output logic [DATA_W-1:0] o_Bus,
  output logic              o_Ready_Bit,
  output logic              o_Disp_Valid,
  output logic [7:0]        o_Disp_Data
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [ADDR_W-1:0] KBSR_ADDR = MMIO_BASE;
  localparam logic [ADDR_W-1:0] KBDR_ADDR = MMIO_BASE + ADDR_W'(2);
  localparam logic [ADDR_W-1:0] DSR_ADDR  = MMIO_BASE + ADDR_W'(4);
  localparam logic [ADDR_W-1:0] DDR_ADDR  = MMIO_BASE + ADDR_W'(6);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;   // address latched at access start
  logic                rw_reg, rw_next;       // direction latched at access start
  logic                ready_bit;

  logic [ADDR_W-1:0]   mar_reg;
  logic [DATA_W-1:0]   mdr_reg;

  logic                kb_flag_reg;           // KBSR[15]
  logic [7:0]          kb_data_reg;
  logic                disp_valid_reg;
  logic [7:0]          disp_data_reg;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   mem_rd_reg;
  logic [MEM_AW-1:0]   mem_idx;

  logic                is_mmio;
  logic                is_mem;
  logic                rd_done;
  logic                wr_done;
  logic                mem_we;
  logic                kbdr_rd;
  logic                ddr_wr;
  logic [DATA_W-1:0]   rd_data;

  // --------------------------------------------------------------------------
  // Address decode of the latched access
  // --------------------------------------------------------------------------
  assign is_mmio = (addr_reg >= MMIO_BASE);
  // Anything below the MMIO page but beyond the array is unmapped.
  assign is_mem  = !is_mmio && ({1'b0, addr_reg} < (ADDR_W + 1)'(DEPTH));
  assign mem_idx = addr_reg[MEM_AW-1:0];

  assign rd_done = (state_reg == ST_READY) && !rw_reg;
  assign wr_done = (state_reg == ST_READY) &&  rw_reg;
  assign mem_we  = wr_done && is_mem;
  assign kbdr_rd = rd_done && is_mmio && (addr_reg == KBDR_ADDR);
  assign ddr_wr  = wr_done && is_mmio && (addr_reg == DDR_ADDR);

  always_comb begin
    rd_data = '0;
    if (is_mmio) begin
      case (addr_reg)
        KBSR_ADDR: rd_data[15]  = kb_flag_reg;
        KBDR_ADDR: rd_data[7:0] = kb_data_reg;
        DSR_ADDR:  rd_data[15]  = ~disp_valid_reg;
        default:   rd_data      = '0;
      endcase
    end else if (is_mem) begin
      rd_data = mem_rd_reg;
    end
  end

  // --------------------------------------------------------------------------
  // Access FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      rw_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      rw_reg    <= rw_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    rw_next    = rw_reg;
    ready_bit  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_MIO_EN) begin
          addr_next = mar_reg;
          rw_next   = i_RW;
          // MMIO registers answer immediately; main memory pays its latency.
          if (mar_reg >= MMIO_BASE) begin
            state_next = ST_READY;
          end else begin
            state_next = ST_BUSY;
            cnt_next   = CNT_W'(MEM_LATENCY - 1);
          end
        end
      end
      ST_BUSY: begin
        if (!i_MIO_EN) begin
          state_next = ST_IDLE;             // abort: nothing is written
        end else if (cnt_reg == '0) begin
          state_next = ST_READY;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_READY: begin
        ready_bit  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_Ready_Bit = ready_bit;

  // --------------------------------------------------------------------------
  // MAR / MDR
  // --------------------------------------------------------------------------
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      mar_reg <= '0;
    end else if (i_LD_MAR) begin
      mar_reg <= i_Bus[ADDR_W-1:0];
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      mdr_reg <= '0;
    end else if (i_LD_MDR) begin
      if (!i_MIO_EN) begin
        mdr_reg <= i_Bus;
      end else if (rd_done) begin
        mdr_reg <= rd_data;
      end
    end
  end

  assign o_Bus = mdr_reg;

  // --------------------------------------------------------------------------
  // Main memory: not reset. The read is registered every cycle from the
  // latched address, so it is settled by the time the FSM reaches READY
  // (main memory always passes through at least one BUSY cycle).
  // --------------------------------------------------------------------------
  always_ff @(posedge i_CLK) begin
    if (mem_we) begin
      mem[mem_idx] <= mdr_reg;
    end
    mem_rd_reg <= mem[mem_idx];
  end

  // --------------------------------------------------------------------------
  // Keyboard: a new character wins over a simultaneous KBDR read clear.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      kb_flag_reg <= 1'b0;
      kb_data_reg <= '0;
    end else if (i_KB_Valid) begin
      kb_flag_reg <= 1'b1;
      kb_data_reg <= i_KB_Data;
    end else if (kbdr_rd) begin
      kb_flag_reg <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Display: a DDR write is accepted only while nothing is pending, judged on
  // the current valid, so a write coinciding with the handshake is dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      disp_valid_reg <= 1'b0;
      disp_data_reg  <= '0;
    end else if (disp_valid_reg && i_Disp_Ready) begin
      disp_valid_reg <= 1'b0;
    end else if (ddr_wr && !disp_valid_reg) begin
      disp_valid_reg <= 1'b1;
      disp_data_reg  <= mdr_reg[7:0];
    end
  end

  assign o_Disp_Valid = disp_valid_reg;
  assign o_Disp_Data  = disp_data_reg;

endmodule

// File: tb/tb_memory_control_mmio.sv
// Directed testbench for memory_control_mmio (default parameters:
// 16-bit data/address, DEPTH=512, MEM_LATENCY=2, MMIO page at 0xFE00).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_memory_control_mmio;

  logic        i_CLK = 1'b0;
  logic        i_RST_N = 1'b0;
  logic        i_LD_MAR = 1'b0;
  logic        i_LD_MDR = 1'b0;
  logic        i_RW = 1'b0;
  logic        i_MIO_EN = 1'b0;
  logic [15:0] i_Bus = '0;
  logic        i_KB_Valid = 1'b0;
  logic [7:0]  i_KB_Data = '0;
  logic        i_Disp_Ready = 1'b0;
  logic [15:0] o_Bus;
  logic        o_Ready_Bit;
  logic        o_Disp_Valid;
  logic [7:0]  o_Disp_Data;

  int errors = 0;
  int checks = 0;

  always #5 i_CLK = ~i_CLK;

  memory_control_mmio dut (
    .i_CLK        (i_CLK),
    .i_RST_N      (i_RST_N),
    .i_LD_MAR     (i_LD_MAR),
    .i_LD_MDR     (i_LD_MDR),
    .i_RW         (i_RW),
    .i_MIO_EN     (i_MIO_EN),
    .i_Bus        (i_Bus),
    .i_KB_Valid   (i_KB_Valid),
    .i_KB_Data    (i_KB_Data),
    .i_Disp_Ready (i_Disp_Ready),
    .o_Bus        (o_Bus),
    .o_Ready_Bit  (o_Ready_Bit),
    .o_Disp_Valid (o_Disp_Valid),
    .o_Disp_Data  (o_Disp_Data)
  );

  // Full access: load MAR, (write) load MDR, raise MIO_EN, count cycles to R.
  // lat = -1 if R never arrives within the budget. Optionally strobes the
  // keyboard during the READY cycle.
  task automatic do_access(input logic [15:0] addr, input logic rw,
                           input logic [15:0] wdata, input logic kb_on_ready,
                           input logic [7:0] kb_char, output int lat);
    @(negedge i_CLK);
    i_Bus = addr; i_LD_MAR = 1'b1;
    @(negedge i_CLK);
    i_LD_MAR = 1'b0;
    if (rw) begin
      i_Bus = wdata; i_LD_MDR = 1'b1;
    end
    @(negedge i_CLK);
    i_Bus = '0; i_RW = rw; i_MIO_EN = 1'b1; i_LD_MDR = !rw;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_CLK);
      if (o_Ready_Bit) begin
        lat = c;
        break;
      end
    end
    if (kb_on_ready && lat > 0) begin
      i_KB_Valid = 1'b1; i_KB_Data = kb_char;
    end
    @(negedge i_CLK);
    i_MIO_EN = 1'b0; i_LD_MDR = 1'b0; i_RW = 1'b0; i_KB_Valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge i_CLK);
    @(negedge i_CLK);
    checks++; if (o_Bus !== 16'h0000) begin errors++; $display("FAIL reset_bus: got %h want 0000", o_Bus); end
    checks++; if (o_Ready_Bit !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", o_Ready_Bit); end
    checks++; if (o_Disp_Valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid: got %b want 0", o_Disp_Valid); end
    checks++; if (o_Disp_Data !== 8'h00) begin errors++; $display("FAIL reset_disp_data: got %h want 00", o_Disp_Data); end
    i_RST_N = 1'b1;
    $display("reset released");
  endtask

  task automatic test_write_read();
    int lat;
    do_access(16'h0000, 1'b1, 16'h1111, 1'b0, 8'h00, lat);
    do_access(16'h0020, 1'b1, 16'h5555, 1'b0, 8'h00, lat);
    do_access(16'h0030, 1'b1, 16'h7777, 1'b0, 8'h00, lat);
    do_access(16'h0010, 1'b1, 16'hBEEF, 1'b0, 8'h00, lat);
    $display("write 0010 BEEF lat=%0d", lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL write_latency: got %0d want 3", lat); end
    i_Bus = 16'h0000; i_LD_MDR = 1'b1;  // clear MDR so readback is meaningful
    @(negedge i_CLK);
    i_LD_MDR = 1'b0;
    do_access(16'h0010, 1'b0, 16'h0000, 1'b0, 8'h00, lat);
    $display("read 0010 -> %h lat=%0d", o_Bus, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d want 3", lat); end
    checks++; if (o_Bus !== 16'hBEEF) begin errors++; $display("FAIL read_0010: got %h want BEEF", o_Bus); end
  endtask

  task automatic test_abort();
    int lat;
    logic r_seen;
    r_seen = 1'b0;
    @(negedge i_CLK); i_Bus = 16'h0020; i_LD_MAR = 1'b1;
    @(negedge i_CLK); i_LD_MAR = 1'b0; i_Bus = 16'h1234; i_LD_MDR = 1'b1;
    @(negedge i_CLK); i_LD_MDR = 1'b0; i_Bus = '0; i_RW = 1'b1; i_MIO_EN = 1'b1;
    @(negedge i_CLK); r_seen = r_seen | o_Ready_Bit; i_MIO_EN = 1'b0; i_RW = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_CLK); r_seen = r_seen | o_Ready_Bit;
    end
    $display("abort write 0020: r_seen=%b", r_seen);
    checks++; if (r_seen !== 1'b0) begin errors++; $display("FAIL abort_no_ready: got %b want 0", r_seen); end
    do_access(16'h0020, 1'b0, 16'h0000, 1'b0, 8'h00, lat);
    $display("read 0020 -> %h", o_Bus);
    checks++; if (o_Bus !== 16'h5555) begin errors++; $display("FAIL abort_mem_kept: got %h want 5555", o_Bus); end
  endtask

  task automatic test_unmapped();
    int lat;
    do_access(16'h0400, 1'b0, 16'h0000, 1'b0, 8'h00, lat);
    $display("read 0400 -> %h lat=%0d", o_Bus, lat);
    checks++; if (o_Bus !== 16'h0000) begin errors++; $display("FAIL unmapped_read: got %h want 0000", o_Bus); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL unmapped_latency: got %0d want 3", lat); end
    do_access(16'h0400, 1'b1, 16'hAAAA, 1'b0, 8'h00, lat);
    do_access(16'h0400, 1'b0, 16'h0000, 1'b0, 8'h00, lat);
    $display("write/read 0400 -> %h", o_Bus);
    checks++; if (o_Bus !== 16'h0000) begin errors++; $display("FAIL unmapped_write: got %h want 0000", o_Bus); end
    do_access(16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, lat);
    $display("read 0000 -> %h", o_Bus);
    checks++; if (o_Bus !== 16'h1111) begin errors++; $display("FAIL unmapped_alias: got %h want 1111", o_Bus); end
  endtask

  task automatic test_keyboard();
    int lat;
    @(negedge i_CLK); i_KB_Valid = 1'b1; i_KB_Data = 8'h41;
    @(negedge i_CLK); i_KB_Valid = 1'b0;
    do_access(16'hFE00, 1'b0, 16'h0000, 1'b0, 8'h00, lat);
    $display("KBSR -> %h lat=%0d", o_Bus, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL mmio_latency: got %0d want 1", lat); end
    checks++; if (o_Bus !== 16'h8000) begin errors++; $display("FAIL kbsr_set: got %h want 8000", o_Bus); end
    do_access(16'hFE02, 1'b0, 16'h0000, 1'b0, 8'h00, lat);
    $display("KBDR -> %h", o_Bus);
    checks++; if (o_Bus !== 16'h0041) begin errors++; $display("FAIL kbdr_data: got %h want 0041", o_Bus); end
    do_access(16'hFE00, 1'b0, 16'h0000, 1'b0, 8'h00, lat);
    $display("KBSR -> %h", o_Bus);
    checks++; if (o_Bus !== 16'h0000) begin errors++; $display("FAIL kbsr_cleared: got %h want 0000", o_Bus); end
    // New character arrives in the very cycle a KBDR read completes.
    @(negedge i_CLK); i_KB_Valid = 1'b1; i_KB_Data = 8'h42;
    @(negedge i_CLK); i_KB_Valid = 1'b0;
    do_access(16'hFE02, 1'b0, 16'h0000, 1'b1, 8'h43, lat);
    $display("KBDR with coincident strobe -> %h", o_Bus);
    checks++; if (o_Bus !== 16'h0042) begin errors++; $display("FAIL kbdr_old_data: got %h want 0042", o_Bus); end
    do_access(16'hFE00, 1'b0, 16'h0000, 1'b0, 8'h00, lat);
    $display("KBSR -> %h", o_Bus);
    checks++; if (o_Bus !== 16'h8000) begin errors++; $display("FAIL kbsr_set_wins: got %h want 8000", o_Bus); end
    do_access(16'hFE02, 1'b0, 16'h0000, 1'b0, 8'h00, lat);
    $display("KBDR -> %h", o_Bus);
    checks++; if (o_Bus !== 16'h0043) begin errors++; $display("FAIL kbdr_new_data: got %h want 0043", o_Bus); end
  endtask

  task automatic test_display();
    int lat;
    do_access(16'hFE04, 1'b0, 16'h0000, 1'b0, 8'h00, lat);
    $display("DSR -> %h", o_Bus);
    checks++; if (o_Bus !== 16'h8000) begin errors++; $display("FAIL dsr_idle: got %h want 8000", o_Bus); end
    do_access(16'hFE06, 1'b1, 16'h0048, 1'b0, 8'h00, lat);
    $display("DDR write 0048: valid=%b data=%h", o_Disp_Valid, o_Disp_Data);
    checks++; if (o_Disp_Valid !== 1'b1) begin errors++; $display("FAIL ddr_valid: got %b want 1", o_Disp_Valid); end
    checks++; if (o_Disp_Data !== 8'h48) begin errors++; $display("FAIL ddr_data: got %h want 48", o_Disp_Data); end
    do_access(16'hFE04, 1'b0, 16'h0000, 1'b0, 8'h00, lat);
    $display("DSR -> %h", o_Bus);
    checks++; if (o_Bus !== 16'h0000) begin errors++; $display("FAIL dsr_busy: got %h want 0000", o_Bus); end
    do_access(16'hFE06, 1'b1, 16'h0055, 1'b0, 8'h00, lat);
    $display("DDR write 0055 while pending: data=%h", o_Disp_Data);
    checks++; if (o_Disp_Data !== 8'h48) begin errors++; $display("FAIL ddr_dropped: got %h want 48", o_Disp_Data); end
    @(negedge i_CLK); i_Disp_Ready = 1'b1;
    @(negedge i_CLK); i_Disp_Ready = 1'b0;
    $display("display handshake: valid=%b", o_Disp_Valid);
    checks++; if (o_Disp_Valid !== 1'b0) begin errors++; $display("FAIL disp_clear: got %b want 0", o_Disp_Valid); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int first_at;
    int second_at;
    pulses = 0; first_at = -1; second_at = -1;
    @(negedge i_CLK); i_Bus = 16'h0010; i_LD_MAR = 1'b1;
    @(negedge i_CLK); i_LD_MAR = 1'b0; i_Bus = '0; i_RW = 1'b0; i_MIO_EN = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge i_CLK);
      if (o_Ready_Bit) begin
        pulses++;
        if (first_at < 0) first_at = c; else second_at = c;
      end
    end
    i_MIO_EN = 1'b0;
    @(negedge i_CLK);
    $display("back-to-back: pulses=%0d at %0d,%0d", pulses, first_at, second_at);
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    checks++; if (second_at !== 7) begin errors++; $display("FAIL b2b_second: got %0d want 7", second_at); end
  endtask

  task automatic test_reset_busy();
    int lat;
    do_access(16'hFE06, 1'b1, 16'h0021, 1'b0, 8'h00, lat);  // leave a display char pending
    @(negedge i_CLK); i_Bus = 16'h0030; i_LD_MAR = 1'b1;
    @(negedge i_CLK); i_LD_MAR = 1'b0; i_Bus = 16'h9999; i_LD_MDR = 1'b1;
    @(negedge i_CLK); i_LD_MDR = 1'b0; i_Bus = '0; i_RW = 1'b1; i_MIO_EN = 1'b1;
    @(negedge i_CLK);
    #1 i_RST_N = 1'b0;
    #1;
    $display("reset in BUSY: bus=%h r=%b dv=%b dd=%h", o_Bus, o_Ready_Bit, o_Disp_Valid, o_Disp_Data);
    checks++; if (o_Bus !== 16'h0000) begin errors++; $display("FAIL rst_busy_bus: got %h want 0000", o_Bus); end
    checks++; if (o_Disp_Valid !== 1'b0) begin errors++; $display("FAIL rst_busy_disp: got %b want 0", o_Disp_Valid); end
    i_MIO_EN = 1'b0; i_RW = 1'b0;
    repeat (3) @(negedge i_CLK);
    i_RST_N = 1'b1;
    do_access(16'h0030, 1'b0, 16'h0000, 1'b0, 8'h00, lat);
    $display("read 0030 after reset -> %h", o_Bus);
    checks++; if (o_Bus !== 16'h7777) begin errors++; $display("FAIL rst_busy_mem: got %h want 7777", o_Bus); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_abort();
    test_unmapped();
    test_keyboard();
    test_display();
    test_back_to_back();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
